// File: rtl/bram_port_pattern_tester_if.sv
// One port of a true dual-port one-cycle block RAM: request side driven by the
// tester (master), read data/valid returned by the RAM (slave).
interface bram_port_pattern_tester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DI;
    logic                  RAM_WE;
    logic                  RAM_RE;
    logic                  RAM_EN;
    logic [DATA_WIDTH-1:0] RAM_DO;
    logic                  RAM_DO_VALID;

    modport master (
        output RAM_ADDR, RAM_DI, RAM_WE, RAM_RE, RAM_EN,
        input  RAM_DO, RAM_DO_VALID
    );

    modport slave (
        input  RAM_ADDR, RAM_DI, RAM_WE, RAM_RE, RAM_EN,
        output RAM_DO, RAM_DO_VALID
    );
endinterface

// File: rtl/bram_port_pattern_tester.sv
// Block RAM port tester: writes seeded pattern to every address, reads back, counts mismatches.
// Define BRAM_TESTER_INVERT_PASS_EN for a second pass with inverted data.
module bram_port_pattern_tester #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [ERR_WIDTH-1:0]  ERR_COUNT,
    output logic                  FIRST_ERR_VALID,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    bram_port_pattern_tester_if.master ram
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;
    localparam logic [ERR_WIDTH-1:0]  ERR_ONE   = ERR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic                  en_q, en_d, we_q, we_d, re_q, re_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  fev_q, fev_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d;
    logic                  inv;
    logic                  mismatch;

`ifdef BRAM_TESTER_INVERT_PASS_EN
    logic pass_q, pass_d;
    assign inv = pass_q;
`else
    assign inv = 1'b0;
`endif

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                      input logic [ADDR_WIDTH-1:0] a,
                                                      input logic                  iv);
        return (s + DATA_WIDTH'(a)) ^ {DATA_WIDTH{iv}};
    endfunction

    // Responses only count while a read phase is outstanding.
    assign mismatch = ram.RAM_DO_VALID && (state_q == S_READ || state_q == S_DRAIN) &&
                      (ram.RAM_DO != pattern(seed_q, exp_addr_q, inv));

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        addr_d     = addr_q;
        exp_addr_d = exp_addr_q;
        di_d       = '0;
        en_d       = 1'b0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        err_d      = err_q;
        fev_d      = fev_q;
        fea_d      = fea_q;
`ifdef BRAM_TESTER_INVERT_PASS_EN
        pass_d     = pass_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_WRITE;
                    seed_d  = SEED;
                    addr_d  = '0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fea_d   = '0;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    di_d    = pattern(SEED, '0, 1'b0);
`ifdef BRAM_TESTER_INVERT_PASS_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                en_d = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    re_d    = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    we_d   = 1'b1;
                    di_d   = pattern(seed_q, addr_q + ADDR_ONE, inv);
                end
            end
            S_READ: begin
                exp_addr_d = addr_q;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    en_d   = 1'b1;
                    re_d   = 1'b1;
                end
            end
            S_DRAIN: begin
`ifdef BRAM_TESTER_INVERT_PASS_EN
                if (!pass_q) begin
                    state_d = S_WRITE;
                    pass_d  = 1'b1;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    di_d    = pattern(seed_q, '0, 1'b1);
                end else begin
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
            if (!fev_q) begin
                fev_d = 1'b1;
                fea_d = exp_addr_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            addr_q     <= '0;
            exp_addr_q <= '0;
            di_q       <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= '0;
            fev_q      <= 1'b0;
            fea_q      <= '0;
`ifdef BRAM_TESTER_INVERT_PASS_EN
            pass_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            addr_q     <= addr_d;
            exp_addr_q <= exp_addr_d;
            di_q       <= di_d;
            en_q       <= en_d;
            we_q       <= we_d;
            re_q       <= re_d;
            err_q      <= err_d;
            fev_q      <= fev_d;
            fea_q      <= fea_d;
`ifdef BRAM_TESTER_INVERT_PASS_EN
            pass_q     <= pass_d;
`endif
        end
    end

    assign BUSY            = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign DONE            = (state_q == S_DONE);
    assign PASS            = DONE && (err_q == '0);
    assign ERR_COUNT       = err_q;
    assign FIRST_ERR_VALID = fev_q;
    assign FIRST_ERR_ADDR  = fea_q;

    assign ram.RAM_ADDR = addr_q;
    assign ram.RAM_DI   = di_q;
    assign ram.RAM_EN   = en_q;
    assign ram.RAM_WE   = we_q;
    assign ram.RAM_RE   = re_q;
endmodule

// File: tb/tb_bram_port_pattern_tester.sv
// Directed bench: two testers (ERR_WIDTH 16 and 3) on ideal/faulty one-cycle RAM models.
module tb_bram_port_pattern_tester;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef BRAM_TESTER_INVERT_PASS_EN
    localparam int LAT    = 2 * (2 * N + 1);
    localparam int PASSES = 2;
`else
    localparam int LAT    = 2 * N + 1;
    localparam int PASSES = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [DW-1:0] SEED = '0;
    int            fault_mode = 0;
    int            checks = 0;
    int            errors = 0;
    int            cyc;

    logic          busy1, done1, pass1, fev1, busy2, done2, pass2, fev2;
    logic [15:0]   err1;
    logic [2:0]    err2;
    logic [AW-1:0] fea1, fea2;
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem2 [N];

    bram_port_pattern_tester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    bram_port_pattern_tester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    bram_port_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(16)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SEED(SEED),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(err1),
        .FIRST_ERR_VALID(fev1), .FIRST_ERR_ADDR(fea1), .ram(bus1)
    );

    bram_port_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(3)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SEED(SEED),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_COUNT(err2),
        .FIRST_ERR_VALID(fev2), .FIRST_ERR_ADDR(fea2), .ram(bus2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d, input logic [AW-1:0] a);
        if (fault_mode == 1 && a == AW'(7)) return d ^ 32'h1;
        if (fault_mode == 2) return '0;
        return d;
    endfunction

    always @(posedge CLK) begin
        bus1.RAM_DO_VALID <= bus1.RAM_EN && bus1.RAM_RE;
        if (bus1.RAM_EN && bus1.RAM_WE) mem1[bus1.RAM_ADDR] <= bus1.RAM_DI;
        if (bus1.RAM_EN && bus1.RAM_RE) bus1.RAM_DO <= corrupt(mem1[bus1.RAM_ADDR], bus1.RAM_ADDR);
        bus2.RAM_DO_VALID <= bus2.RAM_EN && bus2.RAM_RE;
        if (bus2.RAM_EN && bus2.RAM_WE) mem2[bus2.RAM_ADDR] <= bus2.RAM_DI;
        if (bus2.RAM_EN && bus2.RAM_RE) bus2.RAM_DO <= corrupt(mem2[bus2.RAM_ADDR], bus2.RAM_ADDR);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at 1 time unit after the edge that samples START.
    task automatic pulse_start(input logic [DW-1:0] seed);
        @(negedge CLK);
        START = 1'b1;
        SEED  = seed;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic step(input int n, inout int c);
        repeat (n) begin
            @(posedge CLK);
            #1;
            c++;
        end
    endtask

    task automatic wait_done(inout int c);
        while (!done1 && c < 400) begin
            @(posedge CLK);
            #1;
            c++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, busy1, 0);
        chk({tag, " done"}, done1, 0);
        chk({tag, " pass"}, pass1, 0);
        chk({tag, " err"}, err1, 0);
        chk({tag, " fev"}, fev1, 0);
        chk({tag, " fea"}, fea1, 0);
        chk({tag, " ram_en"}, bus1.RAM_EN, 0);
        chk({tag, " ram_we"}, bus1.RAM_WE, 0);
        chk({tag, " ram_re"}, bus1.RAM_RE, 0);
        chk({tag, " ram_addr"}, bus1.RAM_ADDR, 0);
        chk({tag, " ram_di"}, bus1.RAM_DI, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_idle_outputs("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: ideal RAM, seed 5
        pulse_start(32'h5);
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            chk("t1 wr addr", bus1.RAM_ADDR, i);
            chk("t1 wr data", bus1.RAM_DI, 32'h5 + i);
            chk("t1 wr en/we/re", {bus1.RAM_EN, bus1.RAM_WE, bus1.RAM_RE}, 3'b110);
            step(1, cyc);
        end
        chk("t1 rd en/we/re", {bus1.RAM_EN, bus1.RAM_WE, bus1.RAM_RE}, 3'b101);
        chk("t1 rd addr0", bus1.RAM_ADDR, 0);
        wait_done(cyc);
        chk("t1 latency", cyc, LAT);
        chk("t1 pass", pass1, 1);
        chk("t1 err", err1, 0);
        chk("t1 busy", busy1, 0);

        // 2: bit 0 flipped at address 7 (restart from DONE)
        fault_mode = 1;
        pulse_start(32'h5);
        cyc = 0;
        wait_done(cyc);
        chk("t2 latency", cyc, LAT);
        chk("t2 err", err1, PASSES);
        chk("t2 fev", fev1, 1);
        chk("t2 fea", fea1, 7);
        chk("t2 pass", pass1, 0);

        // 3: DO stuck at zero; narrow counter saturates
        fault_mode = 2;
        pulse_start(32'h5);
        cyc = 0;
        wait_done(cyc);
        chk("t3 err", err1, N * PASSES);
        chk("t3 fea", fea1, 0);
        chk("t3 fev", fev1, 1);
        chk("t3 pass", pass1, 0);
        chk("t3 err sat", err2, 7);
        chk("t3 done2", done2, 1);

        // 4: reset during READ at address 9
        fault_mode = 0;
        pulse_start(32'h5);
        cyc = 0;
        step(N + 9, cyc);
        chk("t4 rd addr9", bus1.RAM_ADDR, 9);
        chk("t4 rd re", bus1.RAM_RE, 1);
        RST_N = 1'b0;
        #1;
        chk_idle_outputs("t4 mid-reset");
        @(negedge CLK);
        RST_N = 1'b1;
        pulse_start(32'h5);
        cyc = 0;
        wait_done(cyc);
        chk("t4 latency", cyc, LAT);
        chk("t4 pass", pass1, 1);
        chk("t4 err", err1, 0);

        // 5: START at write address 3 is ignored; START in DONE restarts cleanly
        fault_mode = 2;
        pulse_start(32'h5);
        cyc = 0;
        step(3, cyc);
        chk("t5 at addr3", bus1.RAM_ADDR, 3);
        pulse_start(32'h77);
        cyc++;
        chk("t5 addr after ignored start", bus1.RAM_ADDR, 4);
        chk("t5 data after ignored start", bus1.RAM_DI, 32'h9);
        chk("t5 busy", busy1, 1);
        wait_done(cyc);
        chk("t5 latency w/ ignored start", cyc, LAT);
        chk("t5 err before restart", err1, N * PASSES);
        fault_mode = 0;
        pulse_start(32'hFFFF_FFFE);
        cyc = 0;
        chk("t5 restart err cleared", err1, 0);
        chk("t5 restart fev cleared", fev1, 0);
        chk("t5 restart fea cleared", fea1, 0);
        chk("t5 restart done low", done1, 0);
        chk("t5 restart busy", busy1, 1);
        chk("t5 wrap data a0", bus1.RAM_DI, 32'hFFFF_FFFE);
        step(2, cyc);
        chk("t5 wrap data a2", bus1.RAM_DI, 32'h0);
        wait_done(cyc);
        chk("t5 restart latency", cyc, LAT);
        chk("t5 restart pass", pass1, 1);

`ifdef BRAM_TESTER_INVERT_PASS_EN
        // 6: inverted second pass
        pulse_start(32'h5);
        cyc = 0;
        step(2 * N + 1, cyc);
        chk("t6 pass1 addr0", bus1.RAM_ADDR, 0);
        chk("t6 pass1 we", bus1.RAM_WE, 1);
        chk("t6 pass1 data", bus1.RAM_DI, 32'hFFFF_FFFA);
        wait_done(cyc);
        chk("t6 latency", cyc, 66);
        chk("t6 pass", pass1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
